// File: rtl/right_shift_iter.sv
// right_shift_iter: iterative 32-bit right shifter (logical or arithmetic).
// One bit per clock in SHIFT; with RSHIFT_FAST4_EN defined, four-bit steps
// are taken while at least four positions remain.
// Build option: RSHIFT_FAST4_EN (undefined = single-bit steps only).
module right_shift_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] work, work_next;
  logic [31:0] result_next;
  logic [4:0]  count, count_next;
  logic        fill, fill_next;

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      fill   <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_next;
      work   <= work_next;
      count  <= count_next;
      fill   <= fill_next;
      result <= result_next;
    end
  end

  // Next-state and datapath update; everything holds unless changed below.
  always_comb begin
    state_next  = state;
    work_next   = work;
    count_next  = count;
    fill_next   = fill;
    result_next = result;
    case (state)
      IDLE: begin
        if (start) begin
          work_next  = data_in;
          count_next = shamt;
          fill_next  = arith & data_in[31];
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (count == 5'd0) begin
          result_next = work;
          state_next  = DONE;
        end
`ifdef RSHIFT_FAST4_EN
        else if (count >= 5'd4) begin
          work_next  = {{4{fill}}, work[31:4]};
          count_next = count - 5'd4;
        end
`endif
        else begin
          work_next  = {fill, work[31:1]};
          count_next = count - 5'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status flags decode directly from the state register.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_right_shift_iter.sv
// tb_right_shift_iter: scoreboard bench for right_shift_iter.
// Expected results and completion edges are queued when a start is driven
// and compared when done is observed.
module tb_right_shift_iter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        arith;
  logic [31:0] result;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] res;
    int unsigned done_edge;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fails;
  logic [31:0] last_result;

  right_shift_iter dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .arith   (arith),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter used to timestamp completions.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at edge %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned steps(input logic [4:0] sh);
`ifdef RSHIFT_FAST4_EN
    return int'(sh) / 4 + int'(sh) % 4;
`else
    return int'(sh);
`endif
  endfunction

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh, input logic ar);
    logic signed [31:0] t;
    t = d;
    if (ar) return 32'(t >>> sh);
    return d >> sh;
  endfunction

  // Output monitor: pops the scoreboard on done, checks reset values and
  // that result holds between completions.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      check("rst_result", result, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      last_result = 32'h0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("done_edge", 32'(cyc), 32'(e.done_edge));
      end
      last_result = result;
    end else begin
      check("result_hold", result, last_result);
    end
  end

  // Drive one operation; optionally offer extra starts while busy.
  task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic ar, input bit intf);
    int unsigned s;
    exp_t e;
    s = steps(sh);
    @(negedge clock);
    data_in = d;
    shamt   = sh;
    arith   = ar;
    start   = 1'b1;
    e.res       = model(d, sh, ar);
    e.done_edge = cyc + 1 + s + 1;
    sb.push_back(e);
    for (int k = 0; k <= int'(s) + 1; k++) begin
      @(posedge clock);
      #1;
      check("busy", {31'b0, busy}, 32'h1);
      @(negedge clock);
      start   = intf && (k == 1 || k == int'(s) + 1);
      data_in = $urandom;
      shamt   = 5'($urandom);
      arith   = 1'($urandom);
    end
    @(posedge clock);
    #1;
    check("idle_busy", {31'b0, busy}, 32'h0);
    check("drained", 32'(sb.size()), 32'h0);
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    cyc         = 0;
    n_checks    = 0;
    n_fails     = 0;
    last_result = 32'h0;
    reset       = 1'b1;
    start       = 1'b0;
    data_in     = '0;
    shamt       = '0;
    arith       = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_op(32'h8000_0000, 5'd4,  1'b0, 1'b0);
    run_op(32'h8000_0000, 5'd4,  1'b1, 1'b0);
    run_op(32'h7FFF_FFFF, 5'd4,  1'b1, 1'b0);
    run_op(32'h8000_0000, 5'd31, 1'b1, 1'b0);
    run_op(32'h8000_0000, 5'd31, 1'b0, 1'b0);
    run_op(32'h1234_5678, 5'd0,  1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 5'd8,  1'b0, 1'b1);
    run_op(32'hA5A5_0F0F, 5'd7,  1'b1, 1'b0);
    run_op(32'hC000_0001, 5'd3,  1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom));

    // Abort an operation with reset asserted between clock edges.
    @(negedge clock);
    data_in = 32'h8765_4321;
    shamt   = 5'd20;
    arith   = 1'b1;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    sb.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    run_op(32'hF0F0_1234, 5'd12, 1'b0, 1'b0);

    repeat (3) @(negedge clock);
    check("final_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
